alarm_trigger: RTL and testbench
================================

// Module: alarm_trigger
// PURPOSE
//  Alarm sequencer that drives the buzzer enable input. It compares the running clock time
//  with the stored alarm time on each 1 Hz tick. It handles ringing, snooze, stop, disarm
//  and ring timeout. It sits between the timekeeping/alarm-set logic and the buzzer tone
//  generator, which consumes buzzer_en.
// PARAMETERS
//  RING_SECONDS    60  seconds of ringing before auto-stop (>=1)
//  SNOOZE_MINUTES  5   snooze length in minutes; timer loads SNOOZE_MINUTES*60 seconds
//  SNOOZE_MAX      3   snoozes allowed per alarm event; further snooze presses act as stop
//  CADENCE         1   1: buzzer_en beeps 1 s on / 1 s off while ringing; 0: steady on
// PORTS
//  clk           in   1  system clock (100 MHz)
//  rst           in   1  asynchronous, active-high reset
//  tick_1hz      in   1  single-cycle pulse, once per second, aligned to the seconds increment
//  cur_hour      in   5  current hour, 0-23
//  cur_min       in   6  current minute, 0-59
//  cur_sec       in   6  current second, 0-59
//  alarm_hour    in   5  alarm hour, 0-23
//  alarm_min     in   6  alarm minute, 0-59
//  armed         in   1  level; alarm enabled switch
//  snooze_p      in   1  single-cycle debounced snooze press
//  stop_p        in   1  single-cycle debounced stop press
//  buzzer_en     out  1  registered enable to the buzzer
//  ringing       out  1  registered; state==RINGING
//  snoozed       out  1  registered; state==SNOOZE
//  snooze_count  out  2  snoozes used in the current event
// BEHAVIOUR
//  Reset: state=IDLE. buzzer_en, ringing, snoozed, snooze_count and all timers are 0 immediately.
//  States and transitions, evaluated at posedge clk. Priority, highest first:
//  disarm > stop > snooze > tick-driven events.
//   IDLE:    armed & tick_1hz & cur_hour==alarm_hour & cur_min==alarm_min & cur_sec==0
//            -> RINGING; ring timer=RING_SECONDS; cadence phase=on; snooze_count=0.
//   RINGING: !armed -> IDLE. stop_p -> IDLE.
//            snooze_p & snooze_count<SNOOZE_MAX -> SNOOZE; snooze timer=SNOOZE_MINUTES*60;
//            snooze_count+1.
//            snooze_p & snooze_count==SNOOZE_MAX -> IDLE (same as stop).
//            tick_1hz: ring timer-1 and cadence phase toggles; the tick that takes the ring
//            timer 1->0 -> IDLE.
//   SNOOZE:  !armed or stop_p -> IDLE. snooze_p is ignored.
//            tick_1hz: snooze timer-1; the tick that takes it 1->0 -> RINGING with ring timer
//            reloaded, phase=on, snooze_count kept.
//  A time match outside IDLE is ignored. The match needs cur_sec==0 on a tick, so arming
//  mid-minute (e.g. at 07:00:30) never fires for that minute. Leaving via stop/timeout
//  inside the matching minute does not re-fire.
//  Simultaneous inputs: stop_p with snooze_p -> stop wins. stop_p with tick -> IDLE, no
//  decrement. armed falling with any event -> IDLE.
//  buzzer_en = ringing & (phase | !CADENCE), registered.
//  Latency: matching tick in cycle N -> buzzer_en=1 in cycle N+1. stop_p in cycle N ->
//  buzzer_en=0 in cycle N+1.
//  Widths: ring timer $clog2(RING_SECONDS+1); snooze timer $clog2(SNOOZE_MINUTES*60+1).
//  Counters saturate and never wrap below 0.
//  Reset asserted mid-ring or mid-snooze: outputs drop asynchronously. After release the
//  block stays IDLE until the next exact match.
// STRUCTURE
//  Shared package alarm_pkg:
//   - state enum IDLE/RINGING/SNOOZE, 2-bit encoding
//   - HOUR_W=5, MIN_W=6, SEC_W=6
//   - SECS_PER_MIN=60
//  Sub-module alarm_sec_timer (param MAX) provides the loadable, tick-decremented down
//  counter with a zero-crossing pulse. It is instantiated twice: ring timer and snooze timer.
//  The FSM, match comparator and cadence flop stay in alarm_trigger.
// TESTING
//  - Alarm 07:00, armed, time steps to 07:00:00 on tick -> buzzer_en=1 next cycle.
//    CADENCE=1 gives 1 s on / 1 s off. Auto IDLE after 60 ticks.
//  - Ringing, snooze_p -> snoozed=1, buzzer_en=0. After 300 ticks ringing=1, snooze_count=1.
//    Repeat to SNOOZE_MAX=3; a 4th snooze_p -> IDLE.
//  - Ringing, stop_p and snooze_p in the same cycle -> IDLE, snooze_count unchanged,
//    buzzer_en=0 next cycle.
//  - Arm at 07:00:30 with alarm 07:00 -> no ring through 07:01:00. Ring at 07:00:00 next day.
//  - Disarm during SNOOZE -> IDLE. Re-arm before the snooze timer would expire -> no ring.
//  - rst pulse mid-ring -> buzzer_en=0 without a clock edge. Stays IDLE after release.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and time-field widths for the alarm sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } alarm_state_t;

  localparam int HOUR_W       = 5;
  localparam int MIN_W        = 6;
  localparam int SEC_W        = 6;
  localparam int SECS_PER_MIN = 60;

  // Exact match: same hour and minute, top of the minute.
  function automatic logic time_match(
    input logic [HOUR_W-1:0] cur_h,
    input logic [MIN_W-1:0]  cur_m,
    input logic [SEC_W-1:0]  cur_s,
    input logic [HOUR_W-1:0] alm_h,
    input logic [MIN_W-1:0]  alm_m
  );
    return (cur_h == alm_h) && (cur_m == alm_m) && (cur_s == {SEC_W{1'b0}});
  endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable seconds down-counter; zero_p flags the tick that would take it from 1 to 0.
module alarm_sec_timer import alarm_pkg::*; #(
  parameter int MAX = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic tick,
  input  logic en,
  output logic zero_p
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_C  = W'(MAX);
  localparam logic [W-1:0] ONE_C  = W'(1);
  localparam logic [W-1:0] ZERO_C = W'(0);

  logic [W-1:0] count_r;

  // Down counter: load beats clear beats decrement; saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= ZERO_C;
    end else if (load) begin
      count_r <= MAX_C;
    end else if (clear) begin
      count_r <= ZERO_C;
    end else if (tick && en && (count_r != ZERO_C)) begin
      count_r <= count_r - ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  // Depends only on the raw tick and the count, so the FSM may consume it combinationally.
  assign zero_p = tick && (count_r == ONE_C);

endmodule

// File: rtl/alarm_trigger.sv
// Alarm sequencer: time match, ring/snooze/stop/disarm handling and buzzer cadence.
module alarm_trigger import alarm_pkg::*; #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int SNOOZE_MAX     = 3,
  parameter int CADENCE        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic              armed,
  input  logic              snooze_p,
  input  logic              stop_p,
  output logic              buzzer_en,
  output logic              ringing,
  output logic              snoozed,
  output logic [1:0]        snooze_count
);

  localparam int         SNOOZE_SECS  = SNOOZE_MINUTES * SECS_PER_MIN;
  localparam logic [1:0] SNOOZE_MAX_C = 2'(SNOOZE_MAX);
  localparam logic       CADENCE_C    = (CADENCE != 0);

  alarm_state_t state_r, state_nxt_s;
  logic         phase_r, phase_nxt_s;
  logic [1:0]   count_r, count_nxt_s;
  logic         buzzer_r, ringing_r, snoozed_r;
  logic         buzzer_nxt_s;
  logic         match_s;
  logic         ring_load_s, ring_clear_s, ring_en_s, ring_zero_s;
  logic         snz_load_s, snz_clear_s, snz_en_s, snz_zero_s;

  assign match_s = armed && tick_1hz &&
                   time_match(cur_hour, cur_min, cur_sec, alarm_hour, alarm_min);

  alarm_sec_timer #(.MAX(RING_SECONDS)) u_ring_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (ring_load_s),
    .clear  (ring_clear_s),
    .tick   (tick_1hz),
    .en     (ring_en_s),
    .zero_p (ring_zero_s)
  );

  alarm_sec_timer #(.MAX(SNOOZE_SECS)) u_snooze_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (snz_load_s),
    .clear  (snz_clear_s),
    .tick   (tick_1hz),
    .en     (snz_en_s),
    .zero_p (snz_zero_s)
  );

  // Next-state logic; priority is disarm, stop, snooze, then tick events.
  always_comb begin
    state_nxt_s  = state_r;
    phase_nxt_s  = phase_r;
    count_nxt_s  = count_r;
    ring_load_s  = 1'b0;
    ring_clear_s = 1'b0;
    ring_en_s    = 1'b0;
    snz_load_s   = 1'b0;
    snz_clear_s  = 1'b0;
    snz_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (match_s) begin
          state_nxt_s = RINGING;
          ring_load_s = 1'b1;
          phase_nxt_s = 1'b1;
          count_nxt_s = 2'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RINGING: begin
        if (!armed || stop_p) begin
          state_nxt_s  = IDLE;
          ring_clear_s = 1'b1;
        end else if (snooze_p) begin
          ring_clear_s = 1'b1;
          if (count_r < SNOOZE_MAX_C) begin
            state_nxt_s = SNOOZE;
            snz_load_s  = 1'b1;
            count_nxt_s = count_r + 2'd1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (tick_1hz) begin
          ring_en_s   = 1'b1;
          phase_nxt_s = !phase_r;
          if (ring_zero_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RINGING;
          end
        end else begin
          state_nxt_s = RINGING;
        end
      end
      SNOOZE: begin
        if (!armed || stop_p) begin
          state_nxt_s = IDLE;
          snz_clear_s = 1'b1;
        end else if (tick_1hz) begin
          snz_en_s = 1'b1;
          if (snz_zero_s) begin
            state_nxt_s = RINGING;
            ring_load_s = 1'b1;
            phase_nxt_s = 1'b1;
          end else begin
            state_nxt_s = SNOOZE;
          end
        end else begin
          state_nxt_s = SNOOZE;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        ring_clear_s = 1'b1;
        snz_clear_s  = 1'b1;
      end
    endcase
    buzzer_nxt_s = (state_nxt_s == RINGING) && (phase_nxt_s || !CADENCE_C);
  end

  // State, cadence phase, snooze counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      phase_r   <= 1'b0;
      count_r   <= 2'd0;
      buzzer_r  <= 1'b0;
      ringing_r <= 1'b0;
      snoozed_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      phase_r   <= phase_nxt_s;
      count_r   <= count_nxt_s;
      buzzer_r  <= buzzer_nxt_s;
      ringing_r <= (state_nxt_s == RINGING);
      snoozed_r <= (state_nxt_s == SNOOZE);
    end
  end

  assign buzzer_en    = buzzer_r;
  assign ringing      = ringing_r;
  assign snoozed      = snoozed_r;
  assign snooze_count = count_r;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed self-checking bench for alarm_trigger with default parameters.
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [4:0] cur_hour = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic [4:0] alarm_hour = 5'd7;
  logic [5:0] alarm_min = 6'd0;
  logic       armed = 1'b1;
  logic       snooze_p = 1'b0;
  logic       stop_p = 1'b0;
  logic       buzzer_en;
  logic       ringing;
  logic       snoozed;
  logic [1:0] snooze_count;

  int n_checks = 0;
  int n_errors = 0;

  alarm_trigger dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1hz     (tick_1hz),
    .cur_hour     (cur_hour),
    .cur_min      (cur_min),
    .cur_sec      (cur_sec),
    .alarm_hour   (alarm_hour),
    .alarm_min    (alarm_min),
    .armed        (armed),
    .snooze_p     (snooze_p),
    .stop_p       (stop_p),
    .buzzer_en    (buzzer_en),
    .ringing      (ringing),
    .snoozed      (snoozed),
    .snooze_count (snooze_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One tick with the given time presented; outputs are valid on return.
  task automatic tick_at(input int h, input int m, input int s);
    @(negedge clk);
    cur_hour = 5'(h);
    cur_min  = 6'(m);
    cur_sec  = 6'(s);
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  task automatic press(input logic snz, input logic stp);
    @(negedge clk);
    snooze_p = snz;
    stop_p   = stp;
    @(negedge clk);
    snooze_p = 1'b0;
    stop_p   = 1'b0;
  endtask

  task automatic idle_ticks(input int n, input int h);
    for (int i = 1; i <= n; i++) tick_at(h, (i / 60) % 60, i % 60);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_buzzer", 32'(buzzer_en), 32'd0);
    chk("rst_ringing", 32'(ringing), 32'd0);
    chk("rst_snoozed", 32'(snoozed), 32'd0);
    chk("rst_count", 32'(snooze_count), 32'd0);
    rst = 1'b0;

    // Basic ring, cadence and timeout
    tick_at(6, 59, 59);
    chk("pre_match", 32'(ringing), 32'd0);
    tick_at(7, 0, 0);
    chk("match_buzz", 32'(buzzer_en), 32'd1);
    chk("match_ring", 32'(ringing), 32'd1);
    for (int i = 1; i <= 60; i++) begin
      tick_at(7, i / 60, i % 60);
      if (i == 1) chk("cad_off", 32'(buzzer_en), 32'd0);
      if (i == 2) chk("cad_on", 32'(buzzer_en), 32'd1);
      if (i == 59) begin
        chk("t59_ring", 32'(ringing), 32'd1);
        chk("t59_buzz", 32'(buzzer_en), 32'd0);
      end
      if (i == 60) begin
        chk("timeout_ring", 32'(ringing), 32'd0);
        chk("timeout_buzz", 32'(buzzer_en), 32'd0);
      end
    end

    // Snooze up to the limit, then a further snooze acts as stop
    tick_at(7, 0, 0);
    chk("snz_start_cnt", 32'(snooze_count), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      press(1'b1, 1'b0);
      chk("snz_snoozed", 32'(snoozed), 32'd1);
      chk("snz_ring", 32'(ringing), 32'd0);
      chk("snz_buzz", 32'(buzzer_en), 32'd0);
      chk("snz_cnt", 32'(snooze_count), 32'(k));
      if (k == 1) begin
        press(1'b1, 1'b0);
        chk("snz_ignored", 32'(snoozed), 32'd1);
        chk("snz_ign_cnt", 32'(snooze_count), 32'd1);
      end
      for (int i = 1; i <= 300; i++) begin
        tick_at(8, (i / 60) % 60, i % 60);
        if (i == 299) chk("snz_t299", 32'(snoozed), 32'd1);
      end
      chk("snz_rering", 32'(ringing), 32'd1);
      chk("snz_rebuzz", 32'(buzzer_en), 32'd1);
      chk("snz_keepcnt", 32'(snooze_count), 32'(k));
    end
    press(1'b1, 1'b0);
    chk("snz4_ring", 32'(ringing), 32'd0);
    chk("snz4_snoozed", 32'(snoozed), 32'd0);
    chk("snz4_cnt", 32'(snooze_count), 32'd3);

    // Stop and snooze together: stop wins, count unchanged
    tick_at(7, 0, 0);
    press(1'b1, 1'b0);
    idle_ticks(300, 8);
    chk("ss_rering", 32'(ringing), 32'd1);
    press(1'b1, 1'b1);
    chk("ss_ring", 32'(ringing), 32'd0);
    chk("ss_snoozed", 32'(snoozed), 32'd0);
    chk("ss_buzz", 32'(buzzer_en), 32'd0);
    chk("ss_cnt", 32'(snooze_count), 32'd1);

    // Stop with tick: IDLE
    tick_at(7, 0, 0);
    @(negedge clk);
    stop_p = 1'b1;
    tick_1hz = 1'b1;
    cur_sec = 6'd1;
    @(negedge clk);
    stop_p = 1'b0;
    tick_1hz = 1'b0;
    chk("stoptick_ring", 32'(ringing), 32'd0);

    // Arming mid-minute never fires for that minute
    armed = 1'b0;
    tick_at(7, 0, 0);
    chk("disarmed_match", 32'(ringing), 32'd0);
    tick_at(7, 0, 29);
    armed = 1'b1;
    for (int s = 30; s <= 59; s++) tick_at(7, 0, s);
    tick_at(7, 1, 0);
    chk("midmin_noring", 32'(ringing), 32'd0);
    tick_at(7, 0, 0);
    chk("nextday_ring", 32'(ringing), 32'd1);
    press(1'b0, 1'b1);
    chk("stop_ring", 32'(ringing), 32'd0);

    // Disarm during snooze, re-arm before expiry
    tick_at(7, 0, 0);
    press(1'b1, 1'b0);
    @(negedge clk);
    armed = 1'b0;
    @(negedge clk);
    armed = 1'b1;
    chk("disarm_snoozed", 32'(snoozed), 32'd0);
    chk("disarm_ring", 32'(ringing), 32'd0);
    idle_ticks(310, 9);
    chk("rearm_noring", 32'(ringing), 32'd0);
    chk("rearm_nosnz", 32'(snoozed), 32'd0);

    // Async reset mid-ring
    tick_at(7, 0, 0);
    chk("prerst_buzz", 32'(buzzer_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_buzz", 32'(buzzer_en), 32'd0);
    chk("async_ring", 32'(ringing), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 1; s <= 3; s++) tick_at(7, 0, s);
    chk("postrst_idle", 32'(ringing), 32'd0);
    tick_at(7, 0, 0);
    chk("postrst_match", 32'(ringing), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
